multicycle_control: RTL

- Multicycle successor to the single-cycle opcode decoder for the Duke 550 core. It sequences every instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-state strobes to the PC, IR, register file, data memory and I/O.
- Adds parametrised memory latency and real handshakes with the keyboard input port and the LCD.
- Sits between the IR opcode field and the datapath muxes/enables. It replaces the purely combinational control.

---
 rtl/duke550_ctrl_pkg.sv | 43 ++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/ctrl_decode.sv | 106 ++++++++++
 rtl/multicycle_control.sv | 128 ++++++++++++
 4 files changed

// File: rtl/duke550_ctrl_pkg.sv
// Shared encodings for the Duke 550 multicycle controller: states, opcodes,
// PC/writeback source selects and ALU operations.
package duke550_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StIoWait
    } state_e;

    localparam logic [4:0] OpRtypeMax = 5'b00101;
    localparam logic [4:0] OpAddi     = 5'b00110;
    localparam logic [4:0] OpLw       = 5'b00111;
    localparam logic [4:0] OpSw       = 5'b01000;
    localparam logic [4:0] OpBne      = 5'b01001;
    localparam logic [4:0] OpBgt      = 5'b01010;
    localparam logic [4:0] OpJr       = 5'b01011;
    localparam logic [4:0] OpJ        = 5'b01100;
    localparam logic [4:0] OpJal      = 5'b01101;
    localparam logic [4:0] OpIn       = 5'b01110;
    localparam logic [4:0] OpOut      = 5'b01111;

    localparam logic [1:0] PcSrcInc = 2'd0;
    localparam logic [1:0] PcSrcBr  = 2'd1;
    localparam logic [1:0] PcSrcTgt = 2'd2;
    localparam logic [1:0] PcSrcRd  = 2'd3;

    localparam logic [1:0] RwdAlu = 2'd0;
    localparam logic [1:0] RwdMem = 2'd1;
    localparam logic [1:0] RwdIn  = 2'd2;
    localparam logic [1:0] RwdPc  = 2'd3;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;

    function automatic logic is_rtype(input logic [4:0] op);
        return op <= OpRtypeMax;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the
// datapath / I/O side (slave).
interface multicycle_control_if #(
    parameter int unsigned OP_W    = 5,
    parameter int unsigned ALUOP_W = 3
);
    logic [OP_W-1:0]    op;
    logic               br_cond;
    logic               in_valid;
    logic               lcd_ready;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               ir_we;
    logic               alu_inb;
    logic [ALUOP_W-1:0] alu_op;
    logic               dmem_we;
    logic               rf_we;
    logic               rdst;
    logic [1:0]         rwd;
    logic               input_ack;
    logic               lcd_wren;
    logic               illegal;
    logic               busy;

    modport master (
        input  op, br_cond, in_valid, lcd_ready,
        output pc_we, pc_src, ir_we, alu_inb, alu_op, dmem_we, rf_we, rdst, rwd,
               input_ack, lcd_wren, illegal, busy
    );

    modport slave (
        output op, br_cond, in_valid, lcd_ready,
        input  pc_we, pc_src, ir_we, alu_inb, alu_op, dmem_we, rf_we, rdst, rwd,
               input_ack, lcd_wren, illegal, busy
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational map from controller state and latched opcode to datapath
// strobes; holds no state of its own.
module ctrl_decode
    import duke550_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 3
) (
    input  state_e             state_i,
    input  logic [4:0]         op_i,
    input  logic               fetch_last_i,
    input  logic               br_cond_i,
    input  logic               in_valid_i,
    input  logic               lcd_ready_i,
    output logic               pc_we_o,
    output logic [1:0]         pc_src_o,
    output logic               ir_we_o,
    output logic               alu_inb_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               dmem_we_o,
    output logic               rf_we_o,
    output logic               rdst_o,
    output logic [1:0]         rwd_o,
    output logic               input_ack_o,
    output logic               lcd_wren_o
);

    always_comb begin
        pc_we_o     = 1'b0;
        pc_src_o    = PcSrcInc;
        ir_we_o     = 1'b0;
        alu_inb_o   = 1'b0;
        alu_op_o    = ALUOP_W'(AluAdd);
        dmem_we_o   = 1'b0;
        rf_we_o     = 1'b0;
        rdst_o      = 1'b0;
        rwd_o       = RwdAlu;
        input_ack_o = 1'b0;
        lcd_wren_o  = 1'b0;

        unique case (state_i)
            StFetch: begin
                if (fetch_last_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                end
            end
            StExec: begin
                if (is_rtype(op_i)) begin
                    rf_we_o  = 1'b1;
                    rdst_o   = 1'b1;
                    alu_op_o = ALUOP_W'(op_i[2:0]);
                end else begin
                    case (op_i)
                        OpAddi: begin
                            rf_we_o   = 1'b1;
                            alu_inb_o = 1'b1;
                        end
                        OpLw, OpSw: alu_inb_o = 1'b1;
                        OpBne, OpBgt: begin
                            pc_we_o  = br_cond_i;
                            pc_src_o = PcSrcBr;
                            alu_op_o = ALUOP_W'(AluSub);
                        end
                        OpJr: begin
                            pc_we_o  = 1'b1;
                            pc_src_o = PcSrcRd;
                        end
                        OpJ: begin
                            pc_we_o  = 1'b1;
                            pc_src_o = PcSrcTgt;
                        end
                        // Register file captures the PC already bumped by FETCH.
                        OpJal: begin
                            pc_we_o  = 1'b1;
                            pc_src_o = PcSrcTgt;
                            rf_we_o  = 1'b1;
                            rwd_o    = RwdPc;
                        end
                        default: ;
                    endcase
                end
            end
            StMem: begin
                if (op_i == OpSw) dmem_we_o = 1'b1;
                else              alu_inb_o = 1'b1;
            end
            StWb: begin
                rf_we_o = 1'b1;
                rwd_o   = RwdMem;
            end
            StIoWait: begin
                if (op_i == OpIn) begin
                    if (in_valid_i) begin
                        input_ack_o = 1'b1;
                        rf_we_o     = 1'b1;
                        rwd_o       = RwdIn;
                    end
                end else if (lcd_ready_i) begin
                    lcd_wren_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer for the Duke 550 core: state register,
// memory-latency counter, opcode latch and sticky illegal flag.
module multicycle_control
    import duke550_ctrl_pkg::*;
#(
    parameter int unsigned OP_W     = 5,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned IMEM_LAT = 1,
    parameter int unsigned DMEM_LAT = 1
) (
    input logic                 clock,
    input logic                 reset,
    multicycle_control_if.master bus
);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            illegal_q, illegal_d;

    logic       fetch_last, mem_last, op_legal;
    logic [4:0] op_lo;

    assign fetch_last = cnt_q == 4'(IMEM_LAT - 1);
    assign mem_last   = cnt_q == 4'(DMEM_LAT - 1);
    // Only opcodes 00000-01111 are defined; any higher bit set is illegal.
    assign op_legal   = (bus.op >> 4) == '0;
    assign op_lo      = op_q[4:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;

        unique case (state_q)
            StFetch: begin
                if (fetch_last) state_d = StDecode;
                else            cnt_d   = cnt_q + 4'd1;
            end
            StDecode: begin
                op_d = bus.op;
                if (!op_legal) begin
                    illegal_d = 1'b1;
                    state_d   = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (op_lo == OpLw || op_lo == OpSw)       state_d = StMem;
                else if (op_lo == OpIn || op_lo == OpOut) state_d = StIoWait;
                else                                      state_d = StFetch;
            end
            StMem: begin
                if (op_lo == OpSw)  state_d = StFetch;
                else if (mem_last)  state_d = StWb;
                else                cnt_d   = cnt_q + 4'd1;
            end
            StWb: state_d = StFetch;
            StIoWait: begin
                if ((op_lo == OpIn && bus.in_valid) || (op_lo == OpOut && bus.lcd_ready)) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StFetch;
            cnt_q     <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    logic               dec_pc_we, dec_ir_we, dec_alu_inb, dec_dmem_we, dec_rf_we, dec_rdst;
    logic               dec_input_ack, dec_lcd_wren;
    logic [1:0]         dec_pc_src, dec_rwd;
    logic [ALUOP_W-1:0] dec_alu_op;

    ctrl_decode #(
        .ALUOP_W(ALUOP_W)
    ) u_decode (
        .state_i      (state_q),
        .op_i         (op_lo),
        .fetch_last_i (fetch_last),
        .br_cond_i    (bus.br_cond),
        .in_valid_i   (bus.in_valid),
        .lcd_ready_i  (bus.lcd_ready),
        .pc_we_o      (dec_pc_we),
        .pc_src_o     (dec_pc_src),
        .ir_we_o      (dec_ir_we),
        .alu_inb_o    (dec_alu_inb),
        .alu_op_o     (dec_alu_op),
        .dmem_we_o    (dec_dmem_we),
        .rf_we_o      (dec_rf_we),
        .rdst_o       (dec_rdst),
        .rwd_o        (dec_rwd),
        .input_ack_o  (dec_input_ack),
        .lcd_wren_o   (dec_lcd_wren)
    );

    // Reset masks every output so an aborted instruction cannot write anything.
    assign bus.pc_we     = dec_pc_we & ~reset;
    assign bus.pc_src    = reset ? 2'd0 : dec_pc_src;
    assign bus.ir_we     = dec_ir_we & ~reset;
    assign bus.alu_inb   = dec_alu_inb & ~reset;
    assign bus.alu_op    = reset ? '0 : dec_alu_op;
    assign bus.dmem_we   = dec_dmem_we & ~reset;
    assign bus.rf_we     = dec_rf_we & ~reset;
    assign bus.rdst      = dec_rdst & ~reset;
    assign bus.rwd       = reset ? 2'd0 : dec_rwd;
    assign bus.input_ack = dec_input_ack & ~reset;
    assign bus.lcd_wren  = dec_lcd_wren & ~reset;
    assign bus.illegal   = illegal_q & ~reset;
    assign bus.busy      = ~reset & ((state_q != StFetch) || (cnt_q != 4'd0));

endmodule
